latency_mem: RTL

LATENCY_MEM -- requirements
Module: latency_mem

---
 rtl/latency_mem.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/latency_mem.sv
// Fixed-latency, credit-limited word-addressed memory with in-order responses.
// Byte-masked writes land at the accept edge; reads snapshot the addressed word there.
module latency_mem #(
  parameter int CPU_WIDTH    = 32,
  parameter int MEM_WIDTH    = 128,
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 1,
  parameter int QUEUE_DEPTH  = 4,
  parameter int WRITE_ACK    = 0,
  parameter int TAG_BITS     = 4,
  localparam int LANES       = MEM_WIDTH / CPU_WIDTH,
  localparam int ADDR_W      = $clog2(DEPTH * LANES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_W-1:0]     cpu_req_addr,
  input  logic [CPU_WIDTH-1:0]  cpu_req_data,
  input  logic [CPU_WIDTH/8-1:0] cpu_req_write,
  input  logic [TAG_BITS-1:0]   cpu_req_tag,
  output logic                  cpu_resp_valid,
  input  logic                  cpu_resp_ready,
  output logic [CPU_WIDTH-1:0]  cpu_resp_data,
  output logic                  cpu_resp_write,
  output logic [TAG_BITS-1:0]   cpu_resp_tag
);

  localparam int BYTES     = CPU_WIDTH / 8;
  localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LINE_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W     = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  if (CPU_WIDTH % 8 != 0) begin : g_bad_cpu_width
    $error("CPU_WIDTH must be a multiple of 8");
  end
  if (MEM_WIDTH % CPU_WIDTH != 0 || (LANES & (LANES - 1)) != 0) begin : g_bad_mem_width
    $error("MEM_WIDTH must be a power-of-two multiple of CPU_WIDTH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..8");
  end
  if (QUEUE_DEPTH < 1 || QUEUE_DEPTH > 16) begin : g_bad_queue
    $error("QUEUE_DEPTH must be in 1..16");
  end

  typedef struct packed {
    logic                 valid;
    logic                 write;
    logic [TAG_BITS-1:0]  tag;
    logic [CPU_WIDTH-1:0] data;
  } resp_t;

  // Handshake: a request transfers on a rising edge with cpu_req_valid && cpu_req_ready;
  // a response retires on a rising edge with cpu_resp_valid && cpu_resp_ready, and the
  // response payload holds steady while valid is high and ready is low.

  logic [LINE_BITS-1:0] line_idx;
  logic [LANE_BITS-1:0] lane_idx;

  if (LANES > 1) begin : g_lanes
    assign lane_idx = cpu_req_addr[LANE_BITS-1:0];
    assign line_idx = cpu_req_addr[ADDR_W-1:LANE_BITS];
  end else begin : g_single_lane
    assign lane_idx = '0;
    assign line_idx = cpu_req_addr;
  end

  logic is_write;
  logic accept;
  logic wr_accept;
  logic produce;
  logic retire;
  logic ready_q;

  assign is_write  = |cpu_req_write;
  assign accept    = cpu_req_valid && cpu_req_ready;
  assign wr_accept = accept && is_write;
  assign produce   = accept && (!is_write || (WRITE_ACK != 0));

  // Storage powers up zeroed and is deliberately untouched by reset.
  logic [MEM_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [CPU_WIDTH-1:0] rd_word;

  assign rd_word = mem[line_idx][int'(lane_idx)*CPU_WIDTH +: CPU_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int b = 0; b < BYTES; b++) begin
        if (cpu_req_write[b]) begin
          mem[line_idx][int'(lane_idx)*CPU_WIDTH + b*8 +: 8] <= cpu_req_data[b*8 +: 8];
        end
      end
    end
  end

  // Fixed-length delay line; it never stalls, the queue below absorbs backpressure.
  resp_t pipe [READ_LATENCY];
  resp_t pipe_out;

  assign pipe_out = pipe[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0].valid <= produce;
      pipe[0].write <= is_write;
      pipe[0].tag   <= cpu_req_tag;
      pipe[0].data  <= is_write ? '0 : rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  resp_t              fifo [QUEUE_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  resp_t              head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty = (fifo_cnt == '0);
  // An empty queue lets the delay-line output present directly, so latency stays exact.
  assign head       = fifo_empty ? pipe_out : fifo[rd_ptr];
  assign retire     = cpu_resp_valid && cpu_resp_ready;
  assign push       = pipe_out.valid && !(fifo_empty && retire);
  assign pop        = !fifo_empty && retire;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= pipe_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
    end
  end

  // Credits: everything in the delay line plus everything queued.
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] out_cnt_n;

  always_comb begin
    out_cnt_n = out_cnt;
    if (produce && !retire) begin
      out_cnt_n = out_cnt + CNT_W'(1);
    end else if (!produce && retire) begin
      out_cnt_n = out_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_cnt <= '0;
      ready_q <= 1'b1;
    end else begin
      out_cnt <= out_cnt_n;
      ready_q <= (out_cnt_n < CNT_W'(QUEUE_DEPTH));
    end
  end

  assign cpu_req_ready  = ready_q && reset;
  assign cpu_resp_valid = head.valid && reset;
  assign cpu_resp_data  = head.data;
  assign cpu_resp_write = head.write;
  assign cpu_resp_tag   = head.tag;

endmodule
